// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of the external memory port between icache (ID 0) and dcache (ID 1), with multi-beat write sequencing and tag-based response steering.
// Optional per-requester grant counters are enabled with `define MEM_PORT_ARB_STATS_EN.
module mem_port_arbiter #(
  parameter int ADDR_BITS = 28,
  parameter int DATA_BITS = 128,
  parameter int TAG_BITS  = 5,
  parameter int WR_BEATS  = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ic_req_valid,
  output logic                   ic_req_ready,
  input  logic                   ic_req_rw,
  input  logic [ADDR_BITS-1:0]   ic_req_addr,
  input  logic [TAG_BITS-2:0]    ic_req_tag,
  input  logic                   ic_req_data_valid,
  output logic                   ic_req_data_ready,
  input  logic [DATA_BITS-1:0]   ic_req_data_bits,
  input  logic [DATA_BITS/8-1:0] ic_req_data_mask,
  output logic                   ic_resp_valid,
  output logic [TAG_BITS-2:0]    ic_resp_tag,
  output logic [DATA_BITS-1:0]   ic_resp_data,
  input  logic                   dc_req_valid,
  output logic                   dc_req_ready,
  input  logic                   dc_req_rw,
  input  logic [ADDR_BITS-1:0]   dc_req_addr,
  input  logic [TAG_BITS-2:0]    dc_req_tag,
  input  logic                   dc_req_data_valid,
  output logic                   dc_req_data_ready,
  input  logic [DATA_BITS-1:0]   dc_req_data_bits,
  input  logic [DATA_BITS/8-1:0] dc_req_data_mask,
  output logic                   dc_resp_valid,
  output logic [TAG_BITS-2:0]    dc_resp_tag,
  output logic [DATA_BITS-1:0]   dc_resp_data,
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic                   mem_req_rw,
  output logic [ADDR_BITS-1:0]   mem_req_addr,
  output logic [TAG_BITS-1:0]    mem_req_tag,
  output logic                   mem_req_data_valid,
  input  logic                   mem_req_data_ready,
  output logic [DATA_BITS-1:0]   mem_req_data_bits,
  output logic [DATA_BITS/8-1:0] mem_req_data_mask,
  input  logic                   mem_resp_valid,
  input  logic [TAG_BITS-1:0]    mem_resp_tag,
  input  logic [DATA_BITS-1:0]   mem_resp_data,
  output logic [31:0]            ic_grant_cnt,
  output logic [31:0]            dc_grant_cnt
);
  typedef enum logic [1:0] {IDLE, REQ, WDATA} state_t;
  state_t     state;
  logic       gnt, prio;
  logic [3:0] beat;
  logic       req_hs, data_hs;
  assign mem_req_valid      = state == REQ;
  assign mem_req_rw         = gnt ? dc_req_rw : ic_req_rw;
  assign mem_req_addr       = gnt ? dc_req_addr : ic_req_addr;
  assign mem_req_tag        = {gnt, gnt ? dc_req_tag : ic_req_tag};
  assign mem_req_data_valid = state == WDATA && (gnt ? dc_req_data_valid : ic_req_data_valid);
  assign mem_req_data_bits  = gnt ? dc_req_data_bits : ic_req_data_bits;
  assign mem_req_data_mask  = gnt ? dc_req_data_mask : ic_req_data_mask;
  assign ic_req_ready       = mem_req_valid && !gnt && mem_req_ready;
  assign dc_req_ready       = mem_req_valid && gnt && mem_req_ready;
  assign ic_req_data_ready  = state == WDATA && !gnt && mem_req_data_ready;
  assign dc_req_data_ready  = state == WDATA && gnt && mem_req_data_ready;
  assign req_hs             = mem_req_valid && mem_req_ready;
  assign data_hs            = mem_req_data_valid && mem_req_data_ready;
  // responses are steered purely by the tag's top bit, regardless of FSM state
  assign ic_resp_valid = mem_resp_valid && !mem_resp_tag[TAG_BITS-1];
  assign dc_resp_valid = mem_resp_valid && mem_resp_tag[TAG_BITS-1];
  assign ic_resp_tag   = mem_resp_tag[TAG_BITS-2:0];
  assign dc_resp_tag   = mem_resp_tag[TAG_BITS-2:0];
  assign ic_resp_data  = mem_resp_data;
  assign dc_resp_data  = mem_resp_data;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      gnt   <= 1'b0;
      prio  <= 1'b1;
      beat  <= 4'd0;
    end else begin
      case (state)
        IDLE: if (ic_req_valid || dc_req_valid) begin
          gnt   <= (ic_req_valid && dc_req_valid) ? prio : dc_req_valid;
          state <= REQ;
        end
        REQ: if (req_hs) begin
          if (mem_req_rw) begin
            state <= WDATA;
            beat  <= 4'd0;
          end else begin
            state <= IDLE;
            prio  <= ~gnt;
          end
        end
        WDATA: if (data_hs) begin
          beat <= beat + 4'd1;
          if (beat == 4'(WR_BEATS-1)) begin
            state <= IDLE;
            prio  <= ~gnt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef MEM_PORT_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      ic_grant_cnt <= 32'd0;
      dc_grant_cnt <= 32'd0;
    end else begin
      if (req_hs && !gnt) ic_grant_cnt <= ic_grant_cnt + 32'd1;
      if (req_hs && gnt) dc_grant_cnt <= dc_grant_cnt + 32'd1;
    end
  end
`else
  assign ic_grant_cnt = 32'd0;
  assign dc_grant_cnt = 32'd0;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed tests of arbitration, write sequencing (WR_BEATS=4), response steering, backpressure and reset.
module tb_mem_port_arbiter;
  localparam int A = 28, D = 128, T = 5, B = 4;
  logic clk = 0, reset = 0;
  logic ic_req_valid, ic_req_ready, ic_req_rw, ic_req_data_valid, ic_req_data_ready;
  logic [A-1:0] ic_req_addr;
  logic [T-2:0] ic_req_tag, ic_resp_tag;
  logic [D-1:0] ic_req_data_bits, ic_resp_data;
  logic [D/8-1:0] ic_req_data_mask;
  logic ic_resp_valid;
  logic dc_req_valid, dc_req_ready, dc_req_rw, dc_req_data_valid, dc_req_data_ready;
  logic [A-1:0] dc_req_addr;
  logic [T-2:0] dc_req_tag, dc_resp_tag;
  logic [D-1:0] dc_req_data_bits, dc_resp_data;
  logic [D/8-1:0] dc_req_data_mask;
  logic dc_resp_valid;
  logic mem_req_valid, mem_req_ready, mem_req_rw, mem_req_data_valid, mem_req_data_ready;
  logic [A-1:0] mem_req_addr;
  logic [T-1:0] mem_req_tag, mem_resp_tag;
  logic [D-1:0] mem_req_data_bits, mem_resp_data;
  logic [D/8-1:0] mem_req_data_mask;
  logic mem_resp_valid;
  logic [31:0] ic_grant_cnt, dc_grant_cnt;
  int n_vec = 0, n_err = 0;
`ifdef MEM_PORT_ARB_STATS_EN
  localparam logic [31:0] CNT4 = 32'd4;
`else
  localparam logic [31:0] CNT4 = 32'd0;
`endif

  mem_port_arbiter #(.ADDR_BITS(A), .DATA_BITS(D), .TAG_BITS(T), .WR_BEATS(B)) dut (
    .clk(clk), .reset(reset),
    .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready), .ic_req_rw(ic_req_rw),
    .ic_req_addr(ic_req_addr), .ic_req_tag(ic_req_tag), .ic_req_data_valid(ic_req_data_valid),
    .ic_req_data_ready(ic_req_data_ready), .ic_req_data_bits(ic_req_data_bits),
    .ic_req_data_mask(ic_req_data_mask), .ic_resp_valid(ic_resp_valid),
    .ic_resp_tag(ic_resp_tag), .ic_resp_data(ic_resp_data),
    .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_rw(dc_req_rw),
    .dc_req_addr(dc_req_addr), .dc_req_tag(dc_req_tag), .dc_req_data_valid(dc_req_data_valid),
    .dc_req_data_ready(dc_req_data_ready), .dc_req_data_bits(dc_req_data_bits),
    .dc_req_data_mask(dc_req_data_mask), .dc_resp_valid(dc_resp_valid),
    .dc_resp_tag(dc_resp_tag), .dc_resp_data(dc_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
    .mem_req_addr(mem_req_addr), .mem_req_tag(mem_req_tag),
    .mem_req_data_valid(mem_req_data_valid), .mem_req_data_ready(mem_req_data_ready),
    .mem_req_data_bits(mem_req_data_bits), .mem_req_data_mask(mem_req_data_mask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_tag(mem_resp_tag), .mem_resp_data(mem_resp_data),
    .ic_grant_cnt(ic_grant_cnt), .dc_grant_cnt(dc_grant_cnt)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    ic_req_valid = 0; ic_req_rw = 0; ic_req_addr = '0; ic_req_tag = '0;
    ic_req_data_valid = 0; ic_req_data_bits = '0; ic_req_data_mask = '0;
    dc_req_valid = 0; dc_req_rw = 0; dc_req_addr = '0; dc_req_tag = '0;
    dc_req_data_valid = 0; dc_req_data_bits = '0; dc_req_data_mask = '0;
    mem_req_ready = 0; mem_req_data_ready = 0;
    mem_resp_valid = 0; mem_resp_tag = '0; mem_resp_data = '0;
  endtask

  task automatic do_reset();
    @(negedge clk); idle_inputs(); reset = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk); idle_inputs(); reset = 0;
    ic_req_valid = 1; dc_req_valid = 1; mem_req_ready = 1;
    ic_req_tag = 4'h2; dc_req_tag = 4'h9;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      n_vec++;
      if ({mem_req_valid, ic_req_ready, dc_req_ready, mem_req_data_valid} !== 4'b0) begin
        n_err++; $display("FAIL reset_hold[%0d] valid/ready got %b want 0000", i,
          {mem_req_valid, ic_req_ready, dc_req_ready, mem_req_data_valid});
      end
      n_vec++;
      if (ic_grant_cnt !== 32'd0 || dc_grant_cnt !== 32'd0) begin
        n_err++; $display("FAIL reset_cnt got %0d/%0d want 0/0", ic_grant_cnt, dc_grant_cnt);
      end
    end
    reset = 1;
    @(negedge clk); #1;
    n_vec++;
    if ({mem_req_valid, mem_req_tag, dc_req_ready, ic_req_ready} !== {1'b1, 5'b11001, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL reset_first_grant valid/tag/dr/ir got %b/%b/%b/%b want 1/11001/1/0",
        mem_req_valid, mem_req_tag, dc_req_ready, ic_req_ready);
    end
  endtask

  task automatic test_contention();
    do_reset();
    ic_req_valid = 1; dc_req_valid = 1; mem_req_ready = 1;
    ic_req_tag = 4'h2; dc_req_tag = 4'h9; ic_req_addr = 28'h11; dc_req_addr = 28'h22;
    reset = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      n_vec++;
      if ((i % 2) == 0 ? {mem_req_valid, mem_req_tag, mem_req_addr} !== {1'b1, 5'b11001, 28'h22}
                       : {mem_req_valid, mem_req_tag, mem_req_addr} !== {1'b1, 5'b00010, 28'h11}) begin
        n_err++; $display("FAIL contention_grant[%0d] valid/tag/addr got %b/%b/%h want %s", i,
          mem_req_valid, mem_req_tag, mem_req_addr, (i % 2) == 0 ? "dc" : "ic");
      end
      @(negedge clk); #1;
      n_vec++;
      if (mem_req_valid !== 1'b0) begin
        n_err++; $display("FAIL contention_idle[%0d] mem_req_valid got %b want 0", i, mem_req_valid);
      end
    end
    ic_req_valid = 0; dc_req_valid = 0;
    n_vec++;
    if (ic_grant_cnt !== CNT4 || dc_grant_cnt !== CNT4) begin
      n_err++; $display("FAIL contention_cnt got %0d/%0d want %0d/%0d", ic_grant_cnt, dc_grant_cnt, CNT4, CNT4);
    end
  endtask

  task automatic test_write_beats();
    int k = 0, cyc = 0;
    logic tog = 1;
    logic [D-1:0] bits;
    logic [D/8-1:0] mask;
    do_reset();
    dc_req_valid = 1; dc_req_rw = 1; dc_req_addr = 28'h100; dc_req_tag = 4'h3;
    ic_req_valid = 1; ic_req_rw = 0; ic_req_addr = 28'h55; ic_req_tag = 4'h4;
    mem_req_ready = 1;
    reset = 1;
    @(negedge clk); #1;
    n_vec++;
    if ({mem_req_valid, mem_req_rw, mem_req_addr, mem_req_tag, dc_req_ready} !== {1'b1, 1'b1, 28'h100, 5'b10011, 1'b1}) begin
      n_err++; $display("FAIL write_req valid/rw/addr/tag/dr got %b/%b/%h/%b/%b want 1/1/0000100/10011/1",
        mem_req_valid, mem_req_rw, mem_req_addr, mem_req_tag, dc_req_ready);
    end
    while (k < B && cyc < 20) begin
      @(negedge clk);
      dc_req_valid = 0;
      bits = {4{32'hA5C3_0000 + 32'(k)}};
      mask = 16'h000F << (4 * k);
      dc_req_data_valid = 1; dc_req_data_bits = bits; dc_req_data_mask = mask;
      mem_req_data_ready = tog;
      #1;
      n_vec++;
      if ({mem_req_data_valid, mem_req_data_bits, mem_req_data_mask} !== {1'b1, bits, mask}) begin
        n_err++; $display("FAIL write_beat[%0d] dvalid/bits/mask got %b/%h/%h want 1/%h/%h", k,
          mem_req_data_valid, mem_req_data_bits, mem_req_data_mask, bits, mask);
      end
      n_vec++;
      if ({dc_req_data_ready, ic_req_data_ready, ic_req_ready, mem_req_valid} !== {tog, 3'b000}) begin
        n_err++; $display("FAIL write_ready[%0d] ddr/idr/ir/mv got %b want %b000", k,
          {dc_req_data_ready, ic_req_data_ready, ic_req_ready, mem_req_valid}, tog);
      end
      if (tog) k++;
      tog = ~tog; cyc++;
    end
    n_vec++;
    if (k != B) begin
      n_err++; $display("FAIL write_budget beats got %0d want %0d", k, B);
    end
    @(negedge clk);
    mem_req_data_ready = 1; #1;
    n_vec++;
    if ({mem_req_valid, mem_req_data_valid, dc_req_data_ready} !== 3'b000) begin
      n_err++; $display("FAIL write_done valid/dvalid/ddr got %b want 000",
        {mem_req_valid, mem_req_data_valid, dc_req_data_ready});
    end
    dc_req_data_valid = 0;
    @(negedge clk); #1;
    n_vec++;
    if ({mem_req_valid, mem_req_rw, mem_req_addr, mem_req_tag, ic_req_ready} !== {1'b1, 1'b0, 28'h55, 5'b00100, 1'b1}) begin
      n_err++; $display("FAIL write_ic_after valid/rw/addr/tag/ir got %b/%b/%h/%b/%b want 1/0/0000055/00100/1",
        mem_req_valid, mem_req_rw, mem_req_addr, mem_req_tag, ic_req_ready);
    end
    @(negedge clk); ic_req_valid = 0;
  endtask

  task automatic test_resp_steering();
    @(negedge clk);
    mem_resp_valid = 1; mem_resp_tag = 5'b10011; mem_resp_data = {4{32'hDEAD_BEEF}}; #1;
    n_vec++;
    if ({dc_resp_valid, dc_resp_tag, ic_resp_valid} !== {1'b1, 4'b0011, 1'b0} || dc_resp_data !== {4{32'hDEAD_BEEF}}) begin
      n_err++; $display("FAIL resp_dc dv/dtag/iv got %b/%b/%b data %h want 1/0011/0",
        dc_resp_valid, dc_resp_tag, ic_resp_valid, dc_resp_data);
    end
    mem_resp_tag = 5'b00111; mem_resp_data = {4{32'h1234_5678}}; #1;
    n_vec++;
    if ({ic_resp_valid, ic_resp_tag, dc_resp_valid} !== {1'b1, 4'b0111, 1'b0} || ic_resp_data !== {4{32'h1234_5678}}) begin
      n_err++; $display("FAIL resp_ic iv/itag/dv got %b/%b/%b data %h want 1/0111/0",
        ic_resp_valid, ic_resp_tag, dc_resp_valid, ic_resp_data);
    end
    mem_resp_valid = 0; #1;
    n_vec++;
    if ({ic_resp_valid, dc_resp_valid} !== 2'b00) begin
      n_err++; $display("FAIL resp_none iv/dv got %b want 00", {ic_resp_valid, dc_resp_valid});
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    dc_req_valid = 1; dc_req_addr = 28'h2A; dc_req_tag = 4'h6;
    ic_req_valid = 1; ic_req_addr = 28'h3B; ic_req_tag = 4'h1;
    reset = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      n_vec++;
      if ({mem_req_valid, mem_req_addr, mem_req_tag, dc_req_ready, ic_req_ready} !== {1'b1, 28'h2A, 5'b10110, 2'b00}) begin
        n_err++; $display("FAIL backpressure[%0d] valid/addr/tag/dr/ir got %b/%h/%b/%b/%b want 1/000002a/10110/0/0", i,
          mem_req_valid, mem_req_addr, mem_req_tag, dc_req_ready, ic_req_ready);
      end
    end
    mem_req_ready = 1; #1;
    n_vec++;
    if ({dc_req_ready, ic_req_ready} !== 2'b10) begin
      n_err++; $display("FAIL backpressure_release dr/ir got %b want 10", {dc_req_ready, ic_req_ready});
    end
    @(negedge clk); dc_req_valid = 0; ic_req_valid = 0;
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    dc_req_valid = 1; dc_req_rw = 1; dc_req_addr = 28'h200; dc_req_tag = 4'h5;
    mem_req_ready = 1; mem_req_data_ready = 1;
    reset = 1;
    @(negedge clk);
    @(negedge clk); dc_req_valid = 0; dc_req_data_valid = 1; dc_req_data_bits = {4{32'h0BAD_F00D}};
    @(negedge clk);
    @(negedge clk); #1;
    n_vec++;
    if (mem_req_data_valid !== 1'b1) begin
      n_err++; $display("FAIL midwrite_pre dvalid got %b want 1", mem_req_data_valid);
    end
    reset = 0;
    @(negedge clk); #1;
    n_vec++;
    if ({mem_req_valid, mem_req_data_valid, dc_req_data_ready} !== 3'b000) begin
      n_err++; $display("FAIL midwrite_abort valid/dvalid/ddr got %b want 000",
        {mem_req_valid, mem_req_data_valid, dc_req_data_ready});
    end
    reset = 1; dc_req_data_valid = 0;
    mem_resp_valid = 1; mem_resp_tag = 5'b00001; #1;
    n_vec++;
    if ({ic_resp_valid, ic_resp_tag, dc_resp_valid} !== {1'b1, 4'b0001, 1'b0}) begin
      n_err++; $display("FAIL midwrite_resp iv/itag/dv got %b/%b/%b want 1/0001/0",
        ic_resp_valid, ic_resp_tag, dc_resp_valid);
    end
    @(negedge clk); mem_resp_valid = 0; #1;
    n_vec++;
    if ({mem_req_valid, mem_req_data_valid} !== 2'b00) begin
      n_err++; $display("FAIL midwrite_idle valid/dvalid got %b want 00", {mem_req_valid, mem_req_data_valid});
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_contention();
    test_write_beats();
    test_resp_steering();
    test_backpressure();
    test_reset_mid_write();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single external memory port (req / write-data / resp channels into ExtMemModel) between the instruction cache (requester 0) and the data cache (requester 1) inside riscv_top.
- Round-robin grant FSM; sequences multi-beat writes.
- Tags outgoing requests with the requester ID; steers responses back by tag.

Parameters:
- ADDR_BITS, 28, memory word address width (matches MEM_ADDR_BITS).
- DATA_BITS, 128, data beat width (matches MEM_DATA_BITS).
- TAG_BITS, 5, external tag width; requester tags are TAG_BITS-1 wide.
- WR_BEATS, 1, data beats that follow each write request (range 1..16).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- Each of the two prefixes X = ic (ID 0) and dc (ID 1) has the following ports:
  - X_req_valid  in  1
  - X_req_ready  out  1
  - X_req_rw  in  1  (1 = write)
  - X_req_addr  in  ADDR_BITS
  - X_req_tag  in  TAG_BITS-1
  - X_req_data_valid  in  1
  - X_req_data_ready  out  1
  - X_req_data_bits  in  DATA_BITS
  - X_req_data_mask  in  DATA_BITS/8
  - X_resp_valid  out  1
  - X_resp_tag  out  TAG_BITS-1
  - X_resp_data  out  DATA_BITS
- mem_req_valid  out  1
- mem_req_ready  in  1
- mem_req_rw  out  1
- mem_req_addr  out  ADDR_BITS
- mem_req_tag  out  TAG_BITS  ({ID, requester tag})
- mem_req_data_valid  out  1
- mem_req_data_ready  in  1
- mem_req_data_bits  out  DATA_BITS
- mem_req_data_mask  out  DATA_BITS/8
- mem_resp_valid  in  1
- mem_resp_tag  in  TAG_BITS
- mem_resp_data  in  DATA_BITS
- ic_grant_cnt  out  32  (see Optional Feature)
- dc_grant_cnt  out  32  (see Optional Feature)

Behaviour:
- FSM states: IDLE, REQ, WDATA. Registers: state, gnt (1b), prio (1b), beat (4b).
- Reset (reset==0 at posedge clk):
  - state=IDLE, gnt=0, prio=1 (dcache preferred first), beat=0.
  - All request/data valid/ready outputs 0.
  - Counters 0.
- IDLE:
  - Exactly one X_req_valid: gnt <= that ID.
  - Both valid: gnt <= prio.
  - Any valid: go to REQ next cycle (1-cycle arbitration latency).
  - No requester is ready in IDLE.
- REQ:
  - mem_req_valid=1; rw/addr drive from the granted requester.
  - mem_req_tag = {gnt, granted X_req_tag}.
  - Granted X_req_ready = mem_req_ready; the other X_req_ready = 0.
  - On handshake (valid & ready): rw=1 goes to WDATA with beat=0; rw=0 goes to IDLE and prio <= ~gnt.
  - Requesters must hold valid and payload stable until ready.
  - gnt does not change in REQ, even if the granted requester drops valid (protocol violation; no recovery required).
- WDATA:
  - mem_req_data_valid/bits/mask forward from the granted requester.
  - Granted X_req_data_ready = mem_req_data_ready.
  - Each data handshake increments beat.
  - On the handshake where beat==WR_BEATS-1: go to IDLE, prio <= ~gnt.
  - No new request is presented until the write completes (writes are atomic).
- X_req_data_ready is 0 for both requesters outside WDATA.
- Response routing (combinational, independent of FSM state):
  - X_resp_valid = mem_resp_valid & (mem_resp_tag[TAG_BITS-1]==ID).
  - X_resp_tag = mem_resp_tag[TAG_BITS-2:0].
  - X_resp_data = mem_resp_data to both requesters.
- Multiple reads may be outstanding. Responses arriving during REQ/WDATA are still routed in the same cycle.
- Reset mid-operation:
  - FSM returns to IDLE and drops mem_req_valid / mem_req_data_valid on the next edge.
  - A partially sent write is abandoned.
  - Responses still in flight after reset are routed normally by tag.
- Back-to-back operation: the same requester can win again only if the other is idle; minimum 2 cycles between grants (IDLE + REQ).

Optional Feature:
- Macro: MEM_PORT_ARB_STATS_EN.
- Defined: ic_grant_cnt / dc_grant_cnt increment by 1 on each request-channel handshake for that requester. They wrap at 2^32 and clear on reset.
- Undefined: both outputs tied to 32'd0 and no counter flops are synthesized.

Test Plan:
- Reset hold: reset=0 for 3 cycles with both req_valid=1 -> mem_req_valid=0, both ready=0, counters 0. Release -> dcache is granted first, and mem_req_tag[4]=1.
- Contention: both requesters issue reads continuously, mem_req_ready=1 -> grants alternate dc, ic, dc, ic. With MEM_PORT_ARB_STATS_EN, after 8 grants each counter reads 4.
- Write sequencing with WR_BEATS=4: dc writes addr 0x100, then 4 data beats while mem_req_data_ready toggles 1,0,1,... -> exactly 4 data handshakes and an exact bits/mask passthrough. The ic request waits and is granted only after the 4th beat.
- Response steering: mem_resp_valid=1 with tag 5'b10011 -> dc_resp_valid=1, dc_resp_tag=4'b0011, ic_resp_valid=0. Tag 5'b00111 -> ic_resp_valid=1, ic_resp_tag=4'b0111.
- Backpressure: mem_req_ready=0 for 10 cycles during REQ -> mem_req_valid stays 1, addr/tag stay stable, gnt is unchanged, and the granted X_req_ready stays 0.
- Reset mid-write: assert reset after beat 2 of 4 -> next cycle state=IDLE, mem_req_data_valid=0. A response with tag 5'b00001 arriving the following cycle still produces ic_resp_valid=1.
